// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner family.
// Holds display geometry, pattern/enable vector types and the
// polarity helpers that map "lit/selected" onto pin levels.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_WIDTH  = 7;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Polarity selector values for the *_ACTIVE_LOW parameters.
    localparam bit POL_ACTIVE_HIGH = 1'b0;
    localparam bit POL_ACTIVE_LOW  = 1'b1;

    typedef logic [SEG_WIDTH-1:0]  seg_t;
    typedef logic [NUM_DIGITS-1:0] dig_t;

    // Convert a "1 = lit" segment vector into pin levels.
    function automatic seg_t seg_drive(input seg_t lit, input bit active_low);
        return active_low ? ~lit : lit;
    endfunction

    // Convert a "1 = selected" digit vector into pin levels.
    function automatic dig_t dig_drive(input dig_t sel, input bit active_low);
        return active_low ? ~sel : sel;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Slot timer: counts clocks within one digit slot (0..DIVIDE-1).
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   enable         - 0 holds the counter cleared
//   slot_start     - counter is at 0 (first clock of a slot)
//   blanking       - counter is inside the blanking interval
//   blank_end      - last blanking clock (next clock is the first visible one)
//   wrap           - last clock of the slot
module slot_timer #(
    parameter int DIVIDE = 50000,
    parameter int BLANK  = 500,
    parameter int CNT_W  = $clog2(DIVIDE)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic slot_start,
    output logic blanking,
    output logic blank_end,
    output logic wrap
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign slot_start = (cnt_reg == '0);
    assign blanking   = (cnt_reg <  CNT_W'(BLANK));
    assign blank_end  = (cnt_reg == CNT_W'(BLANK - 1));
    assign wrap       = (cnt_reg == CNT_W'(DIVIDE - 1));

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (wrap) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/sevensegment_scanner.sv
// Four-digit multiplexed seven-segment driver with blanking and PWM dimming.
// Ports:
//   clk, reset                   - system clock, synchronous active-high reset
//   enable                       - 1 = scan, 0 = dark and counters cleared
//   first/second/third/fourth    - lit patterns for digits 0..3 (bit0 = seg a)
//   brightness                   - duty level 0..7 (0 = 1/8, 7 = full)
//   segments                     - shared segment bus, registered
//   digits                       - one-hot digit enables, registered
//   frame_start                  - pulse on the first clock of each digit-0 slot
module sevensegment_scanner
    import sevenseg_pkg::*;
#(
    parameter int DIVIDE         = 50000,
    parameter int BLANK          = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SEG_WIDTH-1:0]  first,
    input  logic [SEG_WIDTH-1:0]  second,
    input  logic [SEG_WIDTH-1:0]  third,
    input  logic [SEG_WIDTH-1:0]  fourth,
    input  logic [2:0]            brightness,
    output logic [SEG_WIDTH-1:0]  segments,
    output logic [NUM_DIGITS-1:0] digits,
    output logic                  frame_start
);

    localparam int CNT_W   = $clog2(DIVIDE);
    localparam bit SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam bit DIG_POL = (DIG_ACTIVE_LOW != 0);

    generate
        if (DIVIDE < 4 || DIVIDE > (1 << 20) || BLANK < 1 || BLANK > DIVIDE - 2) begin : g_bad_params
            $error("sevensegment_scanner: illegal DIVIDE/BLANK combination");
        end
    endgenerate

    logic slot_start;
    logic blanking;
    logic blank_end;
    logic wrap;

    slot_timer #(
        .DIVIDE (DIVIDE),
        .BLANK  (BLANK),
        .CNT_W  (CNT_W)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .slot_start (slot_start),
        .blanking   (blanking),
        .blank_end  (blank_end),
        .wrap       (wrap)
    );

    logic [IDX_W-1:0] idx_reg;
    logic [2:0]       pwm_reg;
    logic [2:0]       pwm_next;
    seg_t             pat_snap_reg;
    logic [2:0]       br_snap_reg;
    seg_t             segments_reg;
    dig_t             digits_reg;
    logic             frame_reg;

    seg_t pats [NUM_DIGITS];
    assign pats[0] = first;
    assign pats[1] = second;
    assign pats[2] = third;
    assign pats[3] = fourth;

    // PWM phase is realigned to the first visible clock so that every
    // brightness level yields the same lit count in each slot regardless
    // of how BLANK relates to the 8-step PWM period.
    always_comb begin
        pwm_next = pwm_reg + 3'd1;
        if (wrap || blank_end) begin
            pwm_next = 3'd0;
        end
    end

    logic visible;
    assign visible = !blanking && (pwm_reg <= br_snap_reg);

    dig_t dig_on;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign dig_on[gi] = visible && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    seg_t seg_on;
    assign seg_on = visible ? pat_snap_reg : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg      <= '0;
            pwm_reg      <= '0;
            pat_snap_reg <= '0;
            br_snap_reg  <= '0;
            segments_reg <= seg_drive('0, SEG_POL);
            digits_reg   <= dig_drive('0, DIG_POL);
            frame_reg    <= 1'b0;
        end else if (!enable) begin
            idx_reg      <= '0;
            pwm_reg      <= '0;
            segments_reg <= seg_drive('0, SEG_POL);
            digits_reg   <= dig_drive('0, DIG_POL);
            frame_reg    <= 1'b0;
        end else begin
            if (wrap) begin
                idx_reg <= idx_reg + 1'b1;
            end
            pwm_reg <= pwm_next;
            // Slot 0 is always blanked, so capturing here never shows a
            // half-updated pattern.
            if (slot_start) begin
                pat_snap_reg <= pats[idx_reg];
                br_snap_reg  <= brightness;
            end
            segments_reg <= seg_drive(seg_on, SEG_POL);
            digits_reg   <= dig_drive(dig_on, DIG_POL);
            frame_reg    <= slot_start && (idx_reg == '0);
        end
    end

    assign segments    = segments_reg;
    assign digits      = digits_reg;
    assign frame_start = frame_reg;

endmodule
